// File: rtl/led_trail_pwm.sv
// led_trail_pwm: per-LED brightness that jumps on a pattern bit, decays over time, and is rendered as PWM
module led_trail_pwm #(
    parameter int N_LED     = 8,
    parameter int PWM_BITS  = 4,
    parameter int DECAY_DIV = 1000000
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] bright,
    input  logic [N_LED-1:0]    led_in,
    output logic [N_LED-1:0]    pwm_out,
    output logic                period_start
);
    localparam int DW = $clog2(DECAY_DIV);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [DW-1:0]       DIV_LAST = DW'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DW-1:0]       r_div_cnt;
    logic [PWM_BITS-1:0] r_level [N_LED];
    logic [PWM_BITS-1:0] w_level_nxt [N_LED];
    logic                w_tick;

    assign w_tick = r_div_cnt == DIV_LAST;

    // Next level per channel: set beats cap clamp beats decay; decay stops at zero.
    always_comb begin
        for (int i = 0; i < N_LED; i++)
            w_level_nxt[i] = led_in[i] ? bright :
                             (r_level[i] > bright) ? bright :
                             (w_tick && r_level[i] != '0) ? r_level[i] - 1'b1 : r_level[i];
    end

    // Counters, levels and registered PWM drive; disabling parks everything at zero.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt    <= '0;
            r_div_cnt    <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < N_LED; i++) r_level[i] <= '0;
        end else if (!enable) begin
            r_pwm_cnt    <= '0;
            r_div_cnt    <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < N_LED; i++) r_level[i] <= '0;
        end else begin
            r_pwm_cnt    <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + 1'b1;
            period_start <= r_pwm_cnt == '0;
            for (int i = 0; i < N_LED; i++) begin
                r_level[i] <= w_level_nxt[i];
                pwm_out[i] <= r_pwm_cnt < r_level[i];
            end
        end
    end
endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm: directed and randomized checks of led_trail_pwm against an arithmetic reference model
module tb_led_trail_pwm;
    localparam int N  = 8;
    localparam int PB = 4;
    localparam int DD = 4;
    localparam int P  = (1 << PB) - 1;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [PB-1:0] bright = '0;
    logic [N-1:0]  led_in = '0;
    logic [N-1:0]  pwm_out;
    logic          period_start;

    int vectors = 0;
    int errors  = 0;

    int           n;
    int           lvl [N];
    logic [N-1:0] exp_pwm;
    logic         exp_ps;

    led_trail_pwm #(.N_LED(N), .PWM_BITS(PB), .DECAY_DIV(DD)) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .bright(bright),
        .led_in(led_in), .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        n = 0;
        for (int i = 0; i < N; i++) lvl[i] = 0;
        exp_pwm = '0;
        exp_ps  = 1'b0;
    endtask

    // n counts enabled edges since the last reset/disable; phase and tick follow by modulo.
    task automatic model_edge();
        int ph;
        if (!rst_n || !enable) begin
            model_clear();
        end else begin
            ph = n % P;
            for (int i = 0; i < N; i++) exp_pwm[i] = ph < lvl[i];
            exp_ps = (ph == 0);
            for (int i = 0; i < N; i++) begin
                if (led_in[i])                         lvl[i] = int'(bright);
                else if (lvl[i] > int'(bright))        lvl[i] = int'(bright);
                else if (n % DD == DD - 1 && lvl[i] > 0) lvl[i] = lvl[i] - 1;
            end
            n++;
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (pwm_out === exp_pwm) else begin
            errors++;
            $error("FAIL %s pwm_out got %h exp %h (t=%0t)", tag, pwm_out, exp_pwm, $time);
        end
        vectors++;
        assert (period_start === exp_ps) else begin
            errors++;
            $error("FAIL %s period_start got %b exp %b (t=%0t)", tag, period_start, exp_ps, $time);
        end
    endtask

    task automatic cycles(input int k, input string tag);
        for (int c = 0; c < k; c++) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
            check(tag);
        end
    endtask

    initial begin
        int on_cnt;
        int ps_cnt;
        model_clear();
        cycles(3, "reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        bright = 4'd15;
        led_in = 8'h01;
        cycles(40, "full_duty");
        bright = 4'd5;
        led_in = 8'hFF;
        cycles(30, "partial_settle");
        on_cnt = 0;
        ps_cnt = 0;
        for (int c = 0; c < P; c++) begin
            cycles(1, "partial");
            on_cnt += (pwm_out == 8'hFF) ? 1 : 0;
            ps_cnt += period_start ? 1 : 0;
        end
        vectors++;
        assert (on_cnt == 5) else begin
            errors++;
            $error("FAIL partial_on_time got %0d exp 5", on_cnt);
        end
        vectors++;
        assert (ps_cnt == 1) else begin
            errors++;
            $error("FAIL period_start_count got %0d exp 1", ps_cnt);
        end
        bright = 4'd15;
        led_in = 8'h01;
        cycles(1, "trail_set");
        led_in = 8'h00;
        cycles(75, "trail_decay");
        vectors++;
        assert (pwm_out === 8'h00) else begin
            errors++;
            $error("FAIL trail_end got %h exp 00", pwm_out);
        end
        led_in = 8'h01;
        cycles(9, "prio_hold");
        led_in = 8'h00;
        bright = 4'd3;
        cycles(32, "cap_clamp");
        led_in = 8'hA5;
        bright = 4'd9;
        cycles(7, "pre_disable");
        enable = 1'b0;
        cycles(3, "disabled");
        led_in = 8'h00;
        enable = 1'b1;
        cycles(20, "reenable_dark");
        led_in = 8'h0F;
        cycles(20, "reenable_set");
        led_in = 8'hFF;
        bright = 4'd15;
        cycles(13, "pre_reset");
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("async_reset");
        cycles(2, "in_reset");
        rst_n = 1'b1;
        cycles(5, "post_reset");
        led_in = 8'h00;
        for (int c = 0; c < 600; c++) begin
            led_in = 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) bright = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 63) != 0);
            cycles(1, "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/led_trail_pwm.md
Name: led_trail_pwm

Overview:
- Downstream consumer of the 8-bit running-light pattern from the LED water stage; drives the physical LED pins.
- Gives each LED a brightness level. The level jumps to a cap whenever the incoming pattern bit is 1, then decays one step per decay tick.
- Each level is rendered as PWM, so the running light leaves a fading trail.
- Sits between the pattern generator and the board LED pins, in the same clock domain.

Parameters:
- N_LED, 8, number of LED channels (width of led_in / pwm_out).
- PWM_BITS, 4, level width; PWM period is 2^PWM_BITS-1 clocks (15 at default).
- DECAY_DIV, 1000000, clocks per decay tick (must be >=2).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = run; 0 = blank outputs and clear levels.
- bright  input  PWM_BITS  global brightness cap applied on set.
- led_in  input  N_LED  pattern from the upstream stage, synchronous to clock.
- pwm_out  output  N_LED  registered PWM drive to the LED pins.
- period_start  output  1  registered one-cycle pulse marking the first cycle of each PWM period.

Behaviour:
- Reset: rst_n low clears, asynchronously and regardless of clock, pwm_cnt, div_cnt, every level[i], pwm_out and period_start to 0. Assertion mid-period is legal. After rst_n rises, the first edge starts at pwm_cnt=0.
- PWM counter pwm_cnt (PWM_BITS wide):
  - Counts 0..2^PWM_BITS-2, then wraps to 0.
  - The all-ones value is never reached, so level 2^PWM_BITS-1 means 100% duty and level 0 means 0%.
- Decay prescaler div_cnt:
  - Counts 0..DECAY_DIV-1 and wraps.
  - decay_tick is high for exactly the one cycle in which div_cnt==DECAY_DIV-1.
  - It is independent of pwm_cnt.
- Level update at each edge, per channel i, in priority order:
  - (1) led_in[i]==1 -> level[i]=bright.
  - (2) else if level[i]>bright -> level[i]=bright (cap clamp when bright is lowered).
  - (3) else if decay_tick and level[i]>0 -> level[i]=level[i]-1.
  - (4) else hold.
  - Level saturates at 0, never wraps.
  - A set coinciding with a decay tick yields bright (set wins).
- Output at each edge:
  - pwm_out[i] <= (pwm_cnt < level[i]), using current register values.
  - period_start <= (pwm_cnt==0).
- Latency:
  - led_in edge -> level 1 clock -> pwm_out 1 clock, so pwm_out responds 2 clocks after led_in is applied.
  - After the first response, pwm_out is high for level[i] cycles of every 2^PWM_BITS-1-cycle period.
- enable==0, effective at the next edge:
  - pwm_cnt=0, div_cnt=0, all level=0, pwm_out=0, period_start=0.
  - led_in is ignored.
- enable rising: the first enabled edge evaluates pwm_cnt=0, so period_start pulses on the following cycle.
- bright==0: a set drives the level to 0, so the LED stays dark; this is legal.
- All arithmetic is unsigned PWM_BITS wide; comparisons are unsigned.
- No combinational path from any input to any output.

Test Plan:
- Common setup: PWM_BITS=4, DECAY_DIV=4 unless stated.
- Reset: run with led_in=8'hFF, then pull rst_n low between edges -> pwm_out=8'h00 and period_start=0 immediately. After release, the first period_start pulse arrives 1 clock after the first edge.
- Full duty: enable=1, bright=15, led_in=8'h01 held -> pwm_out[0]=1 continuously from the 2nd clock onward; bits 7:1 stay 0.
- Partial duty: bright=5, led_in=8'hFF held -> each 15-cycle period pwm_out=8'hFF for 5 cycles then 8'h00 for 10; period_start pulses exactly once every 15 cycles.
- Decay trail: bright=15, led_in=8'h01 for one cycle then 8'h00 -> level[0] decrements once per 4 clocks, reaching 0 after 15 ticks (60 clocks); on-time per period is non-increasing and ends at 0 cycles.
- Priority and cap:
  - Hold led_in[0]=1 across a decay tick -> level stays 15.
  - Then drop bright 15->3 with led_in=0 -> level[0]=3 one clock later, on-time 3 cycles per period.
- Enable: deassert enable mid-period -> pwm_out=8'h00 and levels 0 after one edge. Reassert -> period_start pulses 1 clock after the first enabled edge, and pwm_out stays 0 until led_in sets a level.
